// File: rtl/n4_b10_counter_ctrl.sv
// Run controller for an external 4-digit BCD up counter: command sequencing, prescaled enable, target match and wrap detection.
// Optional lap capture register is built only when N4_B10_CTRL_LAP_EN is defined.
module n4_b10_counter_ctrl #(
  parameter int PRESCALE   = 10,
  parameter int CLR_CYCLES = 2
) (
  input  logic        m_clock,
  input  logic        m_reset_,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  input  logic [15:0] target_in,
  output logic        cmd_ready,
  input  logic [15:0] count_in,
  input  logic        eu_in,
  output logic        c_ei,
  output logic        c_reset_,
  output logic        running,
  output logic        done,
  output logic        ovf,
  input  logic        lap_req,
  output logic [15:0] lap_q
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
  localparam logic [15:0]   PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;
  localparam logic [1:0] CMD_LOAD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   presc_q, presc_d;
  logic [15:0]   target_q, target_d;
  logic [CW-1:0] clr_q, clr_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          cmd_acc;
  logic          match;

  function automatic logic is_bcd(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // A non-BCD target can never be reached by the counter, so it is treated as no target.
  assign match     = (target_q != 16'h0000) && is_bcd(target_q) && (count_in == target_q);
  assign cmd_ready = (state_q != S_CLEAR);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign c_ei      = (state_q == S_RUN) && (presc_q == PRESC_MAX) && !match;
  assign c_reset_  = m_reset_ && (state_q != S_CLEAR);
  assign running   = (state_q == S_RUN);
  assign done      = done_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    target_d = target_q;
    clr_d    = clr_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_acc && cmd == CMD_START) state_d = S_RUN;
      end
      S_RUN: begin
        // Reaching the target takes precedence over a concurrent STOP.
        if (match) state_d = S_DONE;
        else if (cmd_acc && cmd == CMD_STOP) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (cmd_acc && cmd == CMD_START) state_d = S_RUN;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      S_CLEAR: begin
        clr_d = clr_q + CW'(1);
        if (clr_q == CLR_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cmd_acc && cmd == CMD_CLEAR) begin
      state_d = S_CLEAR;
      clr_d   = '0;
    end

    if (cmd_acc && cmd == CMD_LOAD) target_d = target_in;

    if (state_q == S_RUN) begin
      presc_d = (presc_q == PRESC_MAX) ? 16'd0 : presc_q + 16'd1;
    end else if (state_q == S_CLEAR) begin
      presc_d = 16'd0;
    end

    if (c_ei && eu_in) ovf_d = 1'b1;
    if (state_q == S_CLEAR) ovf_d = 1'b0;

    done_d = (state_q == S_RUN) && (state_d == S_DONE);
  end

  always_ff @(posedge m_clock) begin
    if (!m_reset_) begin
      state_q  <= S_IDLE;
      presc_q  <= 16'd0;
      target_q <= 16'h0000;
      clr_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      target_q <= target_d;
      clr_q    <= clr_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

`ifdef N4_B10_CTRL_LAP_EN
  logic [15:0] lap_d;

  always_comb begin
    lap_d = lap_q;
    if (state_q == S_CLEAR) lap_d = 16'h0000;
    else if (lap_req)       lap_d = count_in;
  end

  always_ff @(posedge m_clock) begin
    if (!m_reset_) lap_q <= 16'h0000;
    else           lap_q <= lap_d;
  end
`else
  logic unused_lap_req;
  assign unused_lap_req = lap_req;
  assign lap_q          = 16'h0000;
`endif

endmodule
